control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL provide: clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL provide: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL provide: opcode  input  8  current instruction register contents.
REQ-004 SHALL provide: zeroFlag  input  1  zero register output (1 = last flagged result was zero).
REQ-005 SHALL provide: writeEnableAC / writeEnableR / writeEnableMem  output  1 each  accumulator, R, memory write strobes.
REQ-006 SHALL provide: PCEnable, instructionRegisterEnable, MSBaddressEnable, LSBaddressEnable, zeroEnable  output  1 each  register load enables.
REQ-007 SHALL provide: muxSelectPC  output  1  0 = PC+1, 1 = {MSB,LSB} address.
REQ-008 SHALL provide: muxSelectAddress  output  1  memory address source: 0 = PC, 1 = {MSB,LSB}.
REQ-009 SHALL provide: muxSelectALUtoAC  output  1  AC source: 0 = ALU result, 1 = memory/R mux.
REQ-010 SHALL provide: muxSelectMEM_or_R_toAC  output  1  0 = memory read data, 1 = R.
REQ-011 SHALL provide: muxSelectZero  output  1  Z source: 0 = ALU-result zero detect, 1 = AC-write-data zero detect.
REQ-012 SHALL provide: ALUselectLine  output  3  000 ADD, 001 SUB, 010 INC, 011 CLR, 100 AND, 101 OR, 110 XOR, 111 NOT.
REQ-013 SHALL provide: halted  output  1  high while in HALT.
REQ-014 SHALL provide: instrDone  output  1  one-cycle pulse in the EXEC cycle of every retired instruction.

Function
REQ-015 Memory read SHALL be combinational and memory write synchronous; controller outputs SHALL be decoded combinationally from state, opcode, zeroFlag.
REQ-016 States SHALL be FETCH, DECODE, OPHI, OPLO, EXEC, HALT; every output not listed for a state SHALL be 0.
REQ-017 FETCH: muxSelectAddress=0, instructionRegisterEnable=1, PCEnable=1, muxSelectPC=0; next DECODE.
REQ-018 DECODE: no enables; opcode 0x01,0x02,0x05,0x06,0x07 -> OPHI; 0x00,0x03,0x04,0x08-0x0F -> EXEC; 0x10-0xFF -> HALT.
REQ-019 OPHI: muxSelectAddress=0, MSBaddressEnable=1, PCEnable=1, muxSelectPC=0; next OPLO.
REQ-020 OPLO: as OPHI but LSBaddressEnable=1 instead of MSBaddressEnable; next EXEC.
REQ-021 EXEC (instrDone=1, next FETCH): NOP 0x00 none; LDAC 0x01 muxSelectAddress=1, muxSelectALUtoAC=1, muxSelectMEM_or_R_toAC=0, writeEnableAC=1, zeroEnable=1, muxSelectZero=1.
REQ-022 EXEC: STAC 0x02 muxSelectAddress=1, writeEnableMem=1; MVAC 0x03 writeEnableR=1; MOVR 0x04 muxSelectALUtoAC=1, muxSelectMEM_or_R_toAC=1, writeEnableAC=1, zeroEnable=1, muxSelectZero=1.
REQ-023 EXEC: JUMP 0x05 PCEnable=1, muxSelectPC=1; JMPZ 0x06 same only if zeroFlag=1; JPNZ 0x07 same only if zeroFlag=0; untaken branch leaves PC past operand.
REQ-024 EXEC: opcodes 0x08-0x0F SHALL set ALUselectLine = opcode[2:0], muxSelectALUtoAC=0, writeEnableAC=1, zeroEnable=1, muxSelectZero=0.
REQ-025 ALUselectLine SHALL be 000 in every cycle other than an ALU-op EXEC.
REQ-026 Latency: single-byte instructions 3 cycles, three-byte instructions 5 cycles, FETCH to FETCH.
REQ-027 zeroFlag SHALL be sampled only in EXEC of the branch; opcode SHALL be held stable by the datapath from DECODE to EXEC.
REQ-028 HALT: halted=1, all other outputs 0, state held until reset.

Reset
REQ-029 While reset=1, all outputs SHALL be 0 that cycle (no write reaches any register or memory); state SHALL be FETCH on the next cycle.
REQ-030 Reset in any state, including mid-instruction or HALT, SHALL abandon the instruction with no partial writes after the reset edge.

Verification
REQ-031 Reset, opcode=0x0A -> FETCH (IR/PC enables), DECODE (all 0), EXEC writeEnableAC=1, ALUselectLine=010, zeroEnable=1, instrDone=1, then FETCH.
REQ-032 opcode=0x01 -> OPHI MSBaddressEnable=1, OPLO LSBaddressEnable=1, EXEC writeEnableAC=1, muxSelectAddress=1, muxSelectALUtoAC=1, muxSelectZero=1; 5 cycles total.
REQ-033 opcode=0x06, zeroFlag=0 -> EXEC PCEnable=0; repeat with zeroFlag=1 -> EXEC PCEnable=1, muxSelectPC=1.
REQ-034 opcode=0x02 -> EXEC writeEnableMem=1, muxSelectAddress=1, writeEnableAC=0, zeroEnable=0.
REQ-035 opcode=0x10 -> halted=1 from cycle after DECODE, all enables 0 for 10 cycles; reset -> FETCH, halted=0.
REQ-036 reset asserted during OPLO of STAC -> writeEnableMem never 1, next cycle after reset release is FETCH.

Source files
------------

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
//
// Purpose:
//   Multi-cycle instruction sequencer for a small accumulator machine. Each
//   instruction is fetched, decoded and (for three-byte instructions) has two
//   address bytes loaded before a single execute cycle that drives the
//   datapath write strobes and mux selects. Opcodes 0x10 and above stop the
//   machine until reset.
//
//   Instruction latency, FETCH to FETCH:
//     single-byte (NOP, MVAC, MOVR, ALU ops 0x08-0x0F) : 3 cycles
//     three-byte  (LDAC, STAC, JUMP, JMPZ, JPNZ)       : 5 cycles
//
// Ports:
//   clk                       in   1  system clock, rising-edge active
//   reset                     in   1  synchronous active-high reset
//   opcode                    in   8  instruction register contents
//   zeroFlag                  in   1  Z register (1 = last flagged result zero)
//   writeEnableAC             out  1  accumulator write strobe
//   writeEnableR              out  1  R register write strobe
//   writeEnableMem            out  1  memory write strobe
//   PCEnable                  out  1  program counter load enable
//   instructionRegisterEnable out  1  instruction register load enable
//   MSBaddressEnable          out  1  address high byte load enable
//   LSBaddressEnable          out  1  address low byte load enable
//   zeroEnable                out  1  Z register load enable
//   muxSelectPC               out  1  PC source: 0 = PC+1, 1 = {MSB,LSB}
//   muxSelectAddress          out  1  memory address: 0 = PC, 1 = {MSB,LSB}
//   muxSelectALUtoAC          out  1  AC source: 0 = ALU, 1 = memory/R mux
//   muxSelectMEM_or_R_toAC    out  1  0 = memory read data, 1 = R
//   muxSelectZero             out  1  Z source: 0 = ALU result, 1 = AC data
//   ALUselectLine             out  3  ALU operation (opcode[2:0] of ALU ops)
//   halted                    out  1  high while stopped
//   instrDone                 out  1  one-cycle pulse in each execute cycle
// ---------------------------------------------------------------------------
module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] opcode,
  input  logic       zeroFlag,
  output logic       writeEnableAC,
  output logic       writeEnableR,
  output logic       writeEnableMem,
  output logic       PCEnable,
  output logic       instructionRegisterEnable,
  output logic       MSBaddressEnable,
  output logic       LSBaddressEnable,
  output logic       zeroEnable,
  output logic       muxSelectPC,
  output logic       muxSelectAddress,
  output logic       muxSelectALUtoAC,
  output logic       muxSelectMEM_or_R_toAC,
  output logic       muxSelectZero,
  output logic [2:0] ALUselectLine,
  output logic       halted,
  output logic       instrDone
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    OPHI   = 3'd2,
    OPLO   = 3'd3,
    EXEC   = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_LDAC = 8'h01;
  localparam logic [7:0] OP_STAC = 8'h02;
  localparam logic [7:0] OP_MVAC = 8'h03;
  localparam logic [7:0] OP_MOVR = 8'h04;
  localparam logic [7:0] OP_JUMP = 8'h05;
  localparam logic [7:0] OP_JMPZ = 8'h06;
  localparam logic [7:0] OP_JPNZ = 8'h07;

  state_t state_q, state_d;

  logic isThreeByte;
  logic isHaltOp;
  logic isAluOp;
  logic branchTaken;

  // Opcode classes. Anything with a nonzero upper nibble is undefined and
  // stops the machine; 0x08-0x0F are ALU ops whose low three bits are the
  // ALU function code.
  always_comb begin
    isHaltOp    = (opcode[7:4] != 4'h0);
    isAluOp     = (opcode[7:3] == 5'b00001);
    isThreeByte = (opcode == OP_LDAC) || (opcode == OP_STAC) ||
                  (opcode == OP_JUMP) || (opcode == OP_JMPZ) ||
                  (opcode == OP_JPNZ);
  end

  // Conditional branches look at Z only here, in the execute cycle. An
  // untaken branch simply leaves PC pointing past the two operand bytes.
  always_comb begin
    branchTaken = 1'b0;
    case (opcode)
      OP_JUMP: branchTaken = 1'b1;
      OP_JMPZ: branchTaken = zeroFlag;
      OP_JPNZ: branchTaken = ~zeroFlag;
      default: branchTaken = 1'b0;
    endcase
  end

  // State register. Reset from any state (including HALT) returns to FETCH,
  // abandoning whatever instruction was in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        if (isHaltOp) begin
          state_d = HALT;
        end else if (isThreeByte) begin
          state_d = OPHI;
        end else begin
          state_d = EXEC;
        end
      end
      OPHI:   state_d = OPLO;
      OPLO:   state_d = EXEC;
      EXEC:   state_d = FETCH;
      HALT:   state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Output decode. Everything defaults to 0 and only the strobes/selects
  // that a state actually needs are raised. While reset is high the whole
  // block is suppressed so no register or memory sees a write in the reset
  // cycle, whatever state we happened to be in.
  always_comb begin
    writeEnableAC             = 1'b0;
    writeEnableR              = 1'b0;
    writeEnableMem            = 1'b0;
    PCEnable                  = 1'b0;
    instructionRegisterEnable = 1'b0;
    MSBaddressEnable          = 1'b0;
    LSBaddressEnable          = 1'b0;
    zeroEnable                = 1'b0;
    muxSelectPC               = 1'b0;
    muxSelectAddress          = 1'b0;
    muxSelectALUtoAC          = 1'b0;
    muxSelectMEM_or_R_toAC    = 1'b0;
    muxSelectZero             = 1'b0;
    ALUselectLine             = 3'b000;
    halted                    = 1'b0;
    instrDone                 = 1'b0;

    if (!reset) begin
      unique case (state_q)
        // Read the opcode byte at PC into IR and step PC.
        FETCH: begin
          muxSelectAddress          = 1'b0;
          instructionRegisterEnable = 1'b1;
          PCEnable                  = 1'b1;
          muxSelectPC               = 1'b0;
        end

        DECODE: begin
        end

        // Operand bytes follow the opcode: high address byte first.
        OPHI: begin
          muxSelectAddress = 1'b0;
          MSBaddressEnable = 1'b1;
          PCEnable         = 1'b1;
          muxSelectPC      = 1'b0;
        end

        OPLO: begin
          muxSelectAddress = 1'b0;
          LSBaddressEnable = 1'b1;
          PCEnable         = 1'b1;
          muxSelectPC      = 1'b0;
        end

        EXEC: begin
          instrDone = 1'b1;
          if (isAluOp) begin
            // AC <= ALU result; Z follows the ALU result.
            ALUselectLine    = opcode[2:0];
            muxSelectALUtoAC = 1'b0;
            writeEnableAC    = 1'b1;
            zeroEnable       = 1'b1;
            muxSelectZero    = 1'b0;
          end else begin
            case (opcode)
              OP_NOP: begin
              end
              // AC <= mem[{MSB,LSB}]; Z follows the value written to AC.
              OP_LDAC: begin
                muxSelectAddress       = 1'b1;
                muxSelectALUtoAC       = 1'b1;
                muxSelectMEM_or_R_toAC = 1'b0;
                writeEnableAC          = 1'b1;
                zeroEnable             = 1'b1;
                muxSelectZero          = 1'b1;
              end
              OP_STAC: begin
                muxSelectAddress = 1'b1;
                writeEnableMem   = 1'b1;
              end
              OP_MVAC: begin
                writeEnableR = 1'b1;
              end
              // AC <= R through the same bypass path LDAC uses.
              OP_MOVR: begin
                muxSelectALUtoAC       = 1'b1;
                muxSelectMEM_or_R_toAC = 1'b1;
                writeEnableAC          = 1'b1;
                zeroEnable             = 1'b1;
                muxSelectZero          = 1'b1;
              end
              OP_JUMP, OP_JMPZ, OP_JPNZ: begin
                PCEnable    = branchTaken;
                muxSelectPC = branchTaken;
              end
              default: begin
              end
            endcase
          end
        end

        HALT: begin
          halted = 1'b1;
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
//
// Self-checking bench for control_unit. A reference model turns each opcode
// into the list of per-cycle output vectors the instruction must produce,
// and a compare process checks the DUT against the head of that list on
// every falling edge. The directed stimulus also pins a few cycles against
// hand-computed literal vectors.
// ---------------------------------------------------------------------------
module tb_control_unit;

  // Output bundle, MSB first:
  //  17 weAC 16 weR 15 weMem 14 pcEn 13 irEn 12 msbEn 11 lsbEn 10 zEn
  //   9 selPC 8 selAddr 7 selALUtoAC 6 selMemR 5 selZero 4:2 alu
  //   1 halted 0 done
  typedef struct packed {
    logic       weAC;
    logic       weR;
    logic       weMem;
    logic       pcEn;
    logic       irEn;
    logic       msbEn;
    logic       lsbEn;
    logic       zEn;
    logic       selPC;
    logic       selAddr;
    logic       selALUtoAC;
    logic       selMemR;
    logic       selZero;
    logic [2:0] alu;
    logic       halted;
    logic       done;
  } outs_t;

  logic       clk;
  logic       reset;
  logic [7:0] opcode;
  logic       zeroFlag;

  logic       writeEnableAC;
  logic       writeEnableR;
  logic       writeEnableMem;
  logic       PCEnable;
  logic       instructionRegisterEnable;
  logic       MSBaddressEnable;
  logic       LSBaddressEnable;
  logic       zeroEnable;
  logic       muxSelectPC;
  logic       muxSelectAddress;
  logic       muxSelectALUtoAC;
  logic       muxSelectMEM_or_R_toAC;
  logic       muxSelectZero;
  logic [2:0] ALUselectLine;
  logic       halted;
  logic       instrDone;

  outs_t dutOuts;

  int compared;
  int mismatched;
  int cycleNo;

  // Reference model state
  outs_t expQ[$];
  bit    pendingHalt;
  bit    modelHalted;
  outs_t expNow;

  control_unit dut (
    .clk                       (clk),
    .reset                     (reset),
    .opcode                    (opcode),
    .zeroFlag                  (zeroFlag),
    .writeEnableAC             (writeEnableAC),
    .writeEnableR              (writeEnableR),
    .writeEnableMem            (writeEnableMem),
    .PCEnable                  (PCEnable),
    .instructionRegisterEnable (instructionRegisterEnable),
    .MSBaddressEnable          (MSBaddressEnable),
    .LSBaddressEnable          (LSBaddressEnable),
    .zeroEnable                (zeroEnable),
    .muxSelectPC               (muxSelectPC),
    .muxSelectAddress          (muxSelectAddress),
    .muxSelectALUtoAC          (muxSelectALUtoAC),
    .muxSelectMEM_or_R_toAC    (muxSelectMEM_or_R_toAC),
    .muxSelectZero             (muxSelectZero),
    .ALUselectLine             (ALUselectLine),
    .halted                    (halted),
    .instrDone                 (instrDone)
  );

  assign dutOuts = '{weAC: writeEnableAC, weR: writeEnableR,
                     weMem: writeEnableMem, pcEn: PCEnable,
                     irEn: instructionRegisterEnable, msbEn: MSBaddressEnable,
                     lsbEn: LSBaddressEnable, zEn: zeroEnable,
                     selPC: muxSelectPC, selAddr: muxSelectAddress,
                     selALUtoAC: muxSelectALUtoAC,
                     selMemR: muxSelectMEM_or_R_toAC,
                     selZero: muxSelectZero, alu: ALUselectLine,
                     halted: halted, done: instrDone};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [17:0] got,
                             input logic [17:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s cycle %0d: got %05h want %05h", name, cycleNo,
               got, want);
    end
  endtask

  // Expand one instruction into the outputs of each of its cycles.
  task automatic buildInstr(input logic [7:0] op, input logic z);
    outs_t v;
    v = '0; v.irEn = 1'b1; v.pcEn = 1'b1;
    expQ.push_back(v);
    v = '0;
    expQ.push_back(v);
    if (op >= 8'h10) begin
      pendingHalt = 1'b1;
    end else begin
      if (op inside {8'h01, 8'h02, 8'h05, 8'h06, 8'h07}) begin
        v = '0; v.pcEn = 1'b1; v.msbEn = 1'b1;
        expQ.push_back(v);
        v = '0; v.pcEn = 1'b1; v.lsbEn = 1'b1;
        expQ.push_back(v);
      end
      v = '0;
      v.done = 1'b1;
      if (op >= 8'h08) begin
        v.alu = op[2:0]; v.weAC = 1'b1; v.zEn = 1'b1;
      end else begin
        case (op)
          8'h01: begin
            v.selAddr = 1'b1; v.selALUtoAC = 1'b1; v.weAC = 1'b1;
            v.zEn = 1'b1; v.selZero = 1'b1;
          end
          8'h02: begin v.selAddr = 1'b1; v.weMem = 1'b1; end
          8'h03: v.weR = 1'b1;
          8'h04: begin
            v.selALUtoAC = 1'b1; v.selMemR = 1'b1; v.weAC = 1'b1;
            v.zEn = 1'b1; v.selZero = 1'b1;
          end
          8'h05: begin v.pcEn = 1'b1; v.selPC = 1'b1; end
          8'h06: begin v.pcEn = z; v.selPC = z; end
          8'h07: begin v.pcEn = !z; v.selPC = !z; end
          default: ;
        endcase
      end
      expQ.push_back(v);
    end
  endtask

  // Compare process: one model step and one check per falling edge.
  always @(negedge clk) begin
    cycleNo++;
    if (reset) begin
      expQ.delete();
      pendingHalt = 1'b0;
      modelHalted = 1'b0;
      expNow = '0;
    end else begin
      if (!modelHalted && expQ.size() == 0) begin
        if (pendingHalt) begin
          modelHalted = 1'b1;
          pendingHalt = 1'b0;
        end else begin
          buildInstr(opcode, zeroFlag);
        end
      end
      if (modelHalted) begin
        expNow = '0;
        expNow.halted = 1'b1;
      end else begin
        expNow = expQ.pop_front();
      end
    end
    checkOutput("model", dutOuts, expNow);
  end

  // Start an instruction just after a rising edge so it is seen from the
  // next FETCH; also releases reset.
  task automatic applyStimulus(input logic [7:0] op, input logic z);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    opcode   = op;
    zeroFlag = z;
  endtask

  typedef struct {
    logic [7:0] op;
    logic       z;
    int         cycles;
  } vec_t;

  vec_t vecs[$];

  initial begin
    compared    = 0;
    mismatched  = 0;
    cycleNo     = 0;
    pendingHalt = 1'b0;
    modelHalted = 1'b0;
    reset       = 1'b1;
    opcode      = 8'h00;
    zeroFlag    = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("lit_reset_zero", dutOuts, 18'h00000);

    // INC: FETCH, DECODE, EXEC, then FETCH again
    applyStimulus(8'h0A, 1'b0);
    @(negedge clk);
    checkOutput("lit_0A_fetch", dutOuts, 18'h06000);
    @(negedge clk);
    checkOutput("lit_0A_decode", dutOuts, 18'h00000);
    @(negedge clk);
    checkOutput("lit_0A_exec", dutOuts, 18'h20409);
    checkOutput("lit_0A_alu", 18'(ALUselectLine), 18'h2);

    // LDAC: five cycles with both address bytes loaded
    applyStimulus(8'h01, 1'b0);
    @(negedge clk);
    checkOutput("lit_01_fetch", dutOuts, 18'h06000);
    @(negedge clk);
    @(negedge clk);
    checkOutput("lit_01_ophi", dutOuts, 18'h05000);
    @(negedge clk);
    checkOutput("lit_01_oplo", dutOuts, 18'h04800);
    @(negedge clk);
    checkOutput("lit_01_exec", dutOuts, 18'h205A1);

    // JMPZ untaken then taken
    applyStimulus(8'h06, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("lit_06_z0_exec", dutOuts, 18'h00001);
    applyStimulus(8'h06, 1'b1);
    repeat (5) @(negedge clk);
    checkOutput("lit_06_z1_exec", dutOuts, 18'h04201);

    // STAC completes with a memory write and no AC/Z update
    applyStimulus(8'h02, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("lit_02_exec", dutOuts, 18'h08101);

    // Undefined opcode halts and holds until reset
    applyStimulus(8'h10, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("lit_10_decode", dutOuts, 18'h00000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("lit_halt_hold", dutOuts, 18'h00002);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("lit_halt_reset", dutOuts, 18'h00000);
    applyStimulus(8'h00, 1'b0);
    @(negedge clk);
    checkOutput("lit_after_halt_fetch", dutOuts, 18'h06000);
    repeat (2) @(negedge clk);

    // Reset during OPLO of STAC: no write, then a fresh FETCH
    applyStimulus(8'h02, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("lit_stac_reset_wemem", 18'(writeEnableMem), 18'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("lit_stac_refetch", dutOuts, 18'h06000);
    repeat (4) @(negedge clk);

    // Directed sweep, checked by the model every cycle
    vecs.push_back('{8'h00, 1'b0, 3});
    vecs.push_back('{8'h03, 1'b0, 3});
    vecs.push_back('{8'h04, 1'b1, 3});
    for (int k = 8; k < 16; k++) vecs.push_back('{8'(k), 1'b0, 3});
    vecs.push_back('{8'h05, 1'b0, 5});
    vecs.push_back('{8'h06, 1'b1, 5});
    vecs.push_back('{8'h07, 1'b0, 5});
    vecs.push_back('{8'h07, 1'b1, 5});
    vecs.push_back('{8'h01, 1'b1, 5});
    vecs.push_back('{8'h02, 1'b1, 5});
    vecs.push_back('{8'h0F, 1'b1, 3});
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].z);
      repeat (vecs[i].cycles) @(negedge clk);
    end

    // Halt from 0xFF, then reset out of it
    applyStimulus(8'hFF, 1'b1);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    applyStimulus(8'h03, 1'b0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared,
             mismatched);
    $finish;
  end

endmodule
